// File: rtl/mole_scheduler.sv
// mole_scheduler: round controller for the multi-hole whack-a-mole game.
// Pops up one mole at a time. The gap before each mole and the choice of
// hole both come from a free-running LFSR. Button presses are judged as a
// hit or a miss, and the block keeps score, lives and a difficulty level
// that shortens the pop-up window.
//
// Ports
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   start  : debounced start button (level, edge-detected internally)
//   btn    : debounced whack buttons (level, edge-detected internally)
//   mole   : one-hot mole LEDs (all blink together in OVER)
//   hole   : index of the current or last mole
//   score  : hit count, saturating at 255
//   lives  : remaining lives
//   level  : difficulty level, saturating at 7
//   state  : IDLE=0, GAP=1, UP=2, OVER=3
//   hit    : one-cycle pulse on a hit
//   miss   : one-cycle pulse on a miss
//
// state | meaning
// IDLE  | waiting for start, moles dark, last score still shown
// GAP   | random pause before the next pop-up
// UP    | mole lit, waiting for a whack or window expiry
// OVER  | out of lives, all moles blink until start
module mole_scheduler #(
   parameter int N_HOLES        = 4,
   parameter int TICK_CYCLES    = 1_000_000,
   parameter int WINDOW0        = 100,
   parameter int WINDOW_STEP    = 10,
   parameter int GAP_MIN        = 50,
   parameter int HITS_PER_LEVEL = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [N_HOLES-1:0] btn,
   output logic [N_HOLES-1:0] mole,
   output logic [1:0]         hole,
   output logic [7:0]         score,
   output logic [1:0]         lives,
   output logic [2:0]         level,
   output logic [1:0]         state,
   output logic               hit,
   output logic               miss
);
   localparam int              TW          = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [TW-1:0]   TICK_LAST   = TW'(TICK_CYCLES - 1);
   localparam logic [7:0]      GAP_BASE    = 8'(GAP_MIN);
   localparam logic [7:0]      BLINK_TICKS = 8'd50;
   localparam logic [3:0]      HITS_LAST   = 4'(HITS_PER_LEVEL - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_GAP  = 2'd1,
      S_UP   = 2'd2,
      S_OVER = 2'd3
   } state_t;

   state_t             r_state;
   logic [7:0]         r_lfsr;
   logic [TW-1:0]      r_tick_cnt;
   logic               r_start_prev;
   logic [N_HOLES-1:0] r_btn_prev;
   logic [7:0]         r_cnt;       // gap, window or blink count, depending on state
   logic [3:0]         r_hits;
   logic [N_HOLES-1:0] r_mole;
   logic [1:0]         r_hole;
   logic [7:0]         r_score;
   logic [1:0]         r_lives;
   logic [2:0]         r_level;
   logic               r_hit;
   logic               r_miss;

   logic               w_tick;
   logic               w_start_rise;
   logic [N_HOLES-1:0] w_btn_rise;
   logic [N_HOLES-1:0] w_target;
   logic               w_is_hit;
   logic               w_wrong;
   logic               w_expire;
   logic               w_is_miss;
   logic               w_to_over;
   logic [7:0]         w_gap_load;
   logic [7:0]         w_window;
   logic [1:0]         w_new_hole;
   logic [N_HOLES-1:0] w_new_mole;

   assign w_tick       = (r_state != S_IDLE) && (r_tick_cnt == TICK_LAST);
   assign w_start_rise = start & ~r_start_prev;
   assign w_btn_rise   = btn & ~r_btn_prev;
   assign w_target     = N_HOLES'(1) << r_hole;
   // A correct rise always beats a wrong rise or an expiry in the same cycle.
   assign w_is_hit     = (r_state == S_UP) && w_btn_rise[r_hole];
   assign w_wrong      = |(w_btn_rise & ~w_target);
   assign w_expire     = w_tick && (r_cnt == 8'd1);
   assign w_is_miss    = (r_state == S_UP) && !w_is_hit && (w_wrong || w_expire);
   assign w_to_over    = w_is_miss && (r_lives == 2'd1);
   assign w_gap_load   = GAP_BASE + {1'b0, r_lfsr[6:0]};
   assign w_window     = 8'(WINDOW0 - WINDOW_STEP * int'(r_level));
   // Never light the same hole twice in a row.
   assign w_new_hole   = (r_lfsr[1:0] == r_hole) ? r_lfsr[1:0] + 2'd1 : r_lfsr[1:0];
   assign w_new_mole   = N_HOLES'(1) << w_new_hole;

   // LFSR x^8+x^6+x^5+x^4+1, free-running; edge registers; game tick timer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lfsr       <= 8'hA5;
         r_tick_cnt   <= '0;
         r_start_prev <= 1'b0;
         r_btn_prev   <= '0;
      end else begin
         r_lfsr       <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
         r_start_prev <= start;
         r_btn_prev   <= btn;
         // Restarting on OVER entry keeps the blink phase aligned to entry.
         if (r_state == S_IDLE || w_to_over || w_tick)
            r_tick_cnt <= '0;
         else
            r_tick_cnt <= r_tick_cnt + TW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_hits  <= '0;
         r_mole  <= '0;
         r_hole  <= '0;
         r_score <= '0;
         r_lives <= 2'd3;
         r_level <= '0;
         r_hit   <= 1'b0;
         r_miss  <= 1'b0;
      end else begin
         r_hit  <= 1'b0;
         r_miss <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_mole <= '0;
               if (w_start_rise) begin
                  r_score <= '0;
                  r_lives <= 2'd3;
                  r_level <= '0;
                  r_hits  <= '0;
                  r_cnt   <= w_gap_load;
                  r_state <= S_GAP;
               end
            end
            S_GAP: begin
               if (w_tick) begin
                  if (r_cnt == 8'd1) begin
                     r_hole  <= w_new_hole;
                     r_mole  <= w_new_mole;
                     r_cnt   <= w_window;
                     r_state <= S_UP;
                  end else begin
                     r_cnt <= r_cnt - 8'd1;
                  end
               end
            end
            S_UP: begin
               if (w_is_hit) begin
                  r_mole <= '0;
                  r_hit  <= 1'b1;
                  if (r_score != 8'hFF) r_score <= r_score + 8'd1;
                  if (r_hits == HITS_LAST) begin
                     r_hits <= '0;
                     if (r_level != 3'd7) r_level <= r_level + 3'd1;
                  end else begin
                     r_hits <= r_hits + 4'd1;
                  end
                  r_cnt   <= w_gap_load;
                  r_state <= S_GAP;
               end else if (w_is_miss) begin
                  r_miss  <= 1'b1;
                  r_lives <= r_lives - 2'd1;
                  if (w_to_over) begin
                     r_mole  <= '1;
                     r_cnt   <= BLINK_TICKS;
                     r_state <= S_OVER;
                  end else begin
                     r_mole  <= '0;
                     r_cnt   <= w_gap_load;
                     r_state <= S_GAP;
                  end
               end else if (w_tick) begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            S_OVER: begin
               if (w_start_rise) begin
                  r_mole  <= '0;
                  r_state <= S_IDLE;
               end else if (w_tick) begin
                  if (r_cnt == 8'd1) begin
                     r_mole <= ~r_mole;
                     r_cnt  <= BLINK_TICKS;
                  end else begin
                     r_cnt <= r_cnt - 8'd1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mole  = r_mole;
   assign hole  = r_hole;
   assign score = r_score;
   assign lives = r_lives;
   assign level = r_level;
   assign state = r_state;
   assign hit   = r_hit;
   assign miss  = r_miss;

endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: plays whack-a-mole games with random press timing and
// masks against a game-level model that predicts pop-up edges, holes,
// score, lives and level from the LFSR sequence and tick arithmetic.
module tb_mole_scheduler;
   localparam int T    = 2;
   localparam int W0   = 100;
   localparam int WS   = 10;
   localparam int GMIN = 10;
   localparam int HPL  = 8;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] btn   = 4'h0;
   logic [3:0] mole;
   logic [1:0] hole;
   logic [7:0] score;
   logic [1:0] lives;
   logic [2:0] level;
   logic [1:0] state;
   logic       hit;
   logic       miss;

   mole_scheduler #(
      .N_HOLES(4), .TICK_CYCLES(T), .WINDOW0(W0), .WINDOW_STEP(WS),
      .GAP_MIN(GMIN), .HITS_PER_LEVEL(HPL)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .btn(btn),
      .mole(mole), .hole(hole), .score(score), .lives(lives),
      .level(level), .state(state), .hit(hit), .miss(miss)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Edge count and the LFSR value in effect before the next edge.
   int         cyc = 0;
   logic [7:0] m_lfsr;

   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      // x^8 + x^6 + x^5 + x^4 + 1
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) m_lfsr <= 8'hA5;
      else       m_lfsr <= lfsr_next(m_lfsr);
   end

   // Game model
   int       e0;          // edge at which the game started (tick phase origin)
   int       pop_edge;    // edge at which the next mole lights
   int       exp_edge;    // edge at which the current window expires
   int       over_edge;
   int       m_score, m_lives, m_lvl, m_hits;
   logic [1:0] m_hole = 2'd0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Park at the negedge just before edge n.
   task automatic to_edge(input int n);
      if (cyc > n - 1) check_val("schedule", cyc, n - 1);
      while (cyc < n - 1) @(negedge clk);
   endtask

   function automatic int next_tick(input int n, input int k);
      return e0 + ((n - e0) / T + k) * T;
   endfunction

   task automatic do_start();
      int n;
      int g;
      n = cyc + 1;
      g = GMIN + int'(m_lfsr[6:0]);
      start = 1'b1;
      step();
      start = 1'b0;
      e0 = n;
      m_score = 0; m_lives = 3; m_lvl = 0; m_hits = 0;
      pop_edge = next_tick(n, g);
      check_val("start_state", state, 1);
      check_val("start_score", score, 0);
      check_val("start_lives", lives, 3);
      check_val("start_level", level, 0);
   endtask

   task automatic wait_pop(input bit hold_correct);
      logic [1:0] h;
      logic [1:0] prev;
      to_edge(pop_edge);
      check_val("pre_pop_mole", mole, 0);
      check_val("pre_pop_state", state, 1);
      h = m_lfsr[1:0];
      if (h == m_hole) h = h + 2'd1;
      if (hold_correct) btn = 4'b0001 << h;
      step();
      prev = m_hole;
      m_hole = h;
      check_val("pop_mole", mole, 4'b0001 << h);
      check_val("pop_hole", hole, h);
      check_val("pop_state", state, 2);
      check_val("hole_repeat", hole != prev, 1);
      exp_edge = pop_edge + (W0 - WS * m_lvl) * T;
   endtask

   task automatic press_at(input int n, input logic [3:0] mask);
      logic [3:0] tgt;
      int g;
      bit is_hit;
      bit is_miss;
      to_edge(n);
      check_val("still_up", state, 2);
      check_val("still_miss0", miss, 0);
      tgt = 4'b0001 << m_hole;
      g = GMIN + int'(m_lfsr[6:0]);
      is_hit = |(mask & tgt);
      is_miss = !is_hit && (mask != 4'h0 || n == exp_edge);
      btn = mask;
      step();
      btn = 4'h0;
      if (is_hit) begin
         m_score = (m_score < 255) ? m_score + 1 : 255;
         m_hits++;
         if (m_hits == HPL) begin
            m_hits = 0;
            if (m_lvl < 7) m_lvl++;
         end
         pop_edge = next_tick(n, g);
         check_val("hit_pulse", hit, 1);
         check_val("hit_nomiss", miss, 0);
         check_val("hit_mole", mole, 0);
         check_val("hit_state", state, 1);
         check_val("hit_score", score, m_score);
         check_val("hit_level", level, m_lvl);
      end else if (is_miss) begin
         m_lives--;
         check_val("miss_pulse", miss, 1);
         check_val("miss_nohit", hit, 0);
         check_val("miss_lives", lives, m_lives);
         check_val("miss_mole", mole, (m_lives == 0) ? 4'hF : 4'h0);
         check_val("miss_state", state, (m_lives == 0) ? 3 : 1);
         if (m_lives == 0) over_edge = n;
         else pop_edge = next_tick(n, g);
      end
      step();
      check_val("pulse_len", {30'd0, hit, miss}, 0);
   endtask

   function automatic logic [3:0] wrong_mask();
      logic [1:0] oh;
      oh = m_hole + 2'($urandom_range(1, 3));
      return 4'b0001 << oh;
   endfunction

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int hits_done;
      bit exp1;
      bit exp7;
      int d;
      logic [3:0] tgt;

      // Reset values
      repeat (3) @(negedge clk);
      check_val("rst_state", state, 0);
      check_val("rst_mole", mole, 0);
      check_val("rst_hole", hole, 0);
      check_val("rst_score", score, 0);
      check_val("rst_lives", lives, 3);
      check_val("rst_level", level, 0);
      check_val("rst_pulses", {30'd0, hit, miss}, 0);
      reset = 1'b0;
      step();

      // Reset mid-UP after one hit
      do_start();
      wait_pop(1'b0);
      press_at(pop_edge + 3, 4'b0001 << m_hole);
      wait_pop(1'b0);
      step();
      reset = 1'b1;
      #1;
      check_val("async_state", state, 0);
      check_val("async_mole", mole, 0);
      check_val("async_score", score, 0);
      check_val("async_lives", lives, 3);
      check_val("async_hole", hole, 0);
      m_hole = 2'd0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      step();

      // Buttons ignored in IDLE
      for (int i = 0; i < 4; i++) begin
         btn = 4'($urandom_range(1, 15));
         step();
         btn = 4'h0;
         step();
         check_val("idle_state", state, 0);
         check_val("idle_mole", mole, 0);
         check_val("idle_hit", hit, 0);
      end

      // Game A: hit, wrong press, simultaneous press, held button, expiry, expiry-tick hit, over
      do_start();
      wait_pop(1'b0);
      press_at(pop_edge + int'($urandom_range(1, 40)), 4'b0001 << m_hole);
      wait_pop(1'b0);
      press_at(pop_edge + int'($urandom_range(1, 40)), wrong_mask());
      wait_pop(1'b0);
      tgt = 4'b0001 << m_hole;
      press_at(pop_edge + int'($urandom_range(1, 40)), tgt | wrong_mask());
      wait_pop(1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         check_val("held_nohit", hit, 0);
         check_val("held_state", state, 2);
      end
      btn = 4'h0;
      step();
      press_at(exp_edge, 4'h0);
      wait_pop(1'b0);
      press_at(exp_edge, 4'b0001 << m_hole);
      wait_pop(1'b0);
      to_edge(pop_edge + 2);
      start = 1'b1;
      step();
      start = 1'b0;
      check_val("start_in_up", state, 2);
      press_at(pop_edge + 5, wrong_mask());
      to_edge(over_edge + 50 * T);
      check_val("blink_on", mole, 4'hF);
      step();
      check_val("blink_off", mole, 4'h0);
      to_edge(over_edge + 100 * T);
      check_val("blink_still_off", mole, 4'h0);
      step();
      check_val("blink_on2", mole, 4'hF);
      check_val("over_lives", lives, 0);
      check_val("over_score", score, m_score);

      // Restart
      start = 1'b1;
      step();
      start = 1'b0;
      check_val("restart_state", state, 0);
      check_val("restart_mole", mole, 0);
      check_val("restart_score", score, m_score);
      step();
      do_start();

      // Game B: level ramp, shortened windows, saturation
      hits_done = 0;
      exp1 = 1'b0;
      exp7 = 1'b0;
      while (hits_done < 300) begin
         wait_pop(1'b0);
         if (m_lvl == 1 && !exp1) begin
            exp1 = 1'b1;
            press_at(exp_edge, 4'h0);
         end else if (m_lvl == 7 && !exp7) begin
            exp7 = 1'b1;
            press_at(exp_edge, 4'h0);
         end else begin
            d = int'($urandom_range(1, 20));
            tgt = 4'b0001 << m_hole;
            if ($urandom_range(0, 3) == 0) tgt = tgt | wrong_mask();
            press_at(pop_edge + d, tgt);
            hits_done++;
         end
      end
      check_val("final_score", score, 255);
      check_val("final_level", level, 7);
      check_val("final_lives", lives, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
